// File: rtl/vert_sched_if.sv
// Triangle hand-off bus between the vertex scheduler and the rasterizer.
// Signals are qualified by tri_valid and transfer on a cycle where tri_valid and tri_ready are both high.
interface vert_sched_if #(
    parameter int NUM_TRI = 4
);
    localparam int IW = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;

    logic [IW-1:0] tri_idx;
    logic          tri_valid;
    logic          tri_ready;
    logic          tri_last;
    logic [8:0]    ax;
    logic [8:0]    ay;
    logic [8:0]    bx;
    logic [8:0]    by;
    logic [8:0]    cx;
    logic [8:0]    cy;

    modport master (
        output tri_idx, tri_valid, tri_last, ax, ay, bx, by, cx, cy,
        input  tri_ready
    );

    modport slave (
        input  tri_idx, tri_valid, tri_last, ax, ay, bx, by, cx, cy,
        output tri_ready
    );
endinterface

// File: rtl/vert_sched.sv
// Frame-synchronous vertex scheduler: fetches cos(angle), emits NUM_TRI triangles, advances angle per batch.
// Optional VERT_SCHED_STATS_EN adds overrun / drop_cnt reporting of dropped frame_start pulses.
module vert_sched #(
    parameter int NUM_TRI    = 4,
    parameter int ROM_LAT    = 2,
    parameter int ANGLE_STEP = 1
) (
    input  logic               clk_pix,
    input  logic               resetn,
    input  logic               frame_start,
    output logic [8:0]         rom_addr,
    input  logic signed [11:0] rom_data,
    input  logic [6:0]         z_b,
    input  logic [6:0]         z_c,
    vert_sched_if.master       tri_bus,
    output logic               busy,
    output logic [1:0]         fsm_state
`ifdef VERT_SCHED_STATS_EN
    ,
    output logic               overrun,
    output logic [7:0]         drop_cnt
`endif
);

    localparam int IW = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_CALC    = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    localparam logic [2:0]    LAT_M1   = 3'(ROM_LAT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TRI - 1);
    localparam logic [9:0]    STEP     = 10'(ANGLE_STEP);

    logic [1:0]         state;
    logic [8:0]         angle;
    logic [2:0]         cnt;
    logic signed [11:0] cos_r;
    logic [IW-1:0]      idx_r;
    logic               valid_r;
    logic               last_r;
    logic [8:0]         ax_r, ay_r, bx_r, by_r, cx_r, cy_r;

    // Depth times cos in Q1.10; the >>> 10 floors, and the 9-bit cast wraps as the adders do.
    logic signed [18:0] zb_s, zc_s, cos_s, p_full, q_full;
    logic [8:0]         b_off, c_off;
    logic [9:0]         angle_sum;
    logic [8:0]         angle_next;

    assign zb_s   = $signed({12'd0, z_b});
    assign zc_s   = $signed({12'd0, z_c});
    assign cos_s  = {{7{cos_r[11]}}, cos_r};
    assign p_full = -(zb_s * cos_s);
    assign q_full = zc_s * cos_s;
    assign b_off  = 9'(p_full >>> 10);
    assign c_off  = 9'(q_full >>> 10);

    always_comb begin
        angle_sum  = {1'b0, angle} + STEP;
        angle_next = angle_sum[8:0];
        if (angle_sum >= 10'd360) angle_next = 9'(angle_sum - 10'd360);
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            angle   <= '0;
            cnt     <= '0;
            cos_r   <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            ax_r    <= '0;
            ay_r    <= '0;
            bx_r    <= '0;
            by_r    <= '0;
            cx_r    <= '0;
            cy_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                        idx_r <= '0;
                    end
                end
                S_FETCH: begin
                    if (cnt == LAT_M1) begin
                        cos_r <= rom_data;
                        state <= S_CALC;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_CALC: begin
                    ax_r    <= 9'd320;
                    ay_r    <= 9'd120;
                    bx_r    <= 9'd320 + b_off;
                    by_r    <= 9'd240 + {2'b00, z_b};
                    cx_r    <= 9'd320 + c_off;
                    cy_r    <= 9'd240 + {2'b00, z_c};
                    last_r  <= (idx_r == LAST_IDX);
                    valid_r <= 1'b1;
                    state   <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (tri_bus.tri_ready) begin
                        valid_r <= 1'b0;
                        if (last_r) begin
                            last_r <= 1'b0;
                            idx_r  <= '0;
                            angle  <= angle_next;
                            state  <= S_IDLE;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                            state <= S_CALC;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef VERT_SCHED_STATS_EN
    // Any frame_start outside IDLE is dropped, including one coinciding with the last handshake.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (frame_start && state != S_IDLE) begin
            overrun <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    assign rom_addr          = angle;
    assign busy              = (state != S_IDLE);
    assign fsm_state         = state;
    assign tri_bus.tri_idx   = idx_r;
    assign tri_bus.tri_valid = valid_r;
    assign tri_bus.tri_last  = last_r;
    assign tri_bus.ax        = ax_r;
    assign tri_bus.ay        = ay_r;
    assign tri_bus.bx        = bx_r;
    assign tri_bus.by        = by_r;
    assign tri_bus.cx        = cx_r;
    assign tri_bus.cy        = cy_r;

endmodule

// File: tb/tb_vert_sched.sv
// Bench for vert_sched: triangle scoreboard fed from a bench-side arithmetic model, plus latency,
// backpressure, dropped-frame, reset and angle-wrap scenarios (stats checks when VERT_SCHED_STATS_EN).
module tb_vert_sched;
    localparam int NUM_TRI = 2;
    localparam int ROM_LAT = 2;
    localparam int IW      = 1;
    localparam int TW      = IW + 1 + 54;

    logic               clk_pix = 1'b0;
    logic               resetn  = 1'b0;
    logic               frame_start = 1'b0;
    logic               frame_start2 = 1'b0;
    logic               ready = 1'b0;
    logic signed [11:0] cos_val = '0;
    logic [6:0]         zb_tab [0:NUM_TRI-1];
    logic [6:0]         zc_tab [0:NUM_TRI-1];
    logic [6:0]         z_b, z_c;
    logic [8:0]         rom_addr, rom_addr2;
    logic               busy, busy2;
    logic [1:0]         fsm_state, fsm_state2;
`ifdef VERT_SCHED_STATS_EN
    logic               overrun, overrun2;
    logic [7:0]         drop_cnt, drop_cnt2;
`endif

    int total = 0;
    int bad   = 0;
    int exp_angle = 0;
    logic [TW-1:0] exp_q[$];

    always #5 clk_pix = ~clk_pix;

    vert_sched_if #(.NUM_TRI(NUM_TRI)) tb1 ();
    vert_sched_if #(.NUM_TRI(1))       tb2 ();

    assign tb1.tri_ready = ready;
    assign tb2.tri_ready = 1'b1;
    assign z_b = zb_tab[tb1.tri_idx];
    assign z_c = zc_tab[tb1.tri_idx];

    vert_sched #(.NUM_TRI(NUM_TRI), .ROM_LAT(ROM_LAT), .ANGLE_STEP(1)) u_dut (
        .clk_pix(clk_pix), .resetn(resetn), .frame_start(frame_start),
        .rom_addr(rom_addr), .rom_data(cos_val), .z_b(z_b), .z_c(z_c),
        .tri_bus(tb1), .busy(busy), .fsm_state(fsm_state)
`ifdef VERT_SCHED_STATS_EN
        , .overrun(overrun), .drop_cnt(drop_cnt)
`endif
    );

    vert_sched #(.NUM_TRI(1), .ROM_LAT(1), .ANGLE_STEP(359)) u_dut2 (
        .clk_pix(clk_pix), .resetn(resetn), .frame_start(frame_start2),
        .rom_addr(rom_addr2), .rom_data(12'sd0), .z_b(7'd0), .z_c(7'd0),
        .tri_bus(tb2), .busy(busy2), .fsm_state(fsm_state2)
`ifdef VERT_SCHED_STATS_EN
        , .overrun(overrun2), .drop_cnt(drop_cnt2)
`endif
    );

    function automatic int floor_1024(int v);
        if (v >= 0) return v / 1024;
        return -((-v + 1023) / 1024);
    endfunction

    function automatic logic [TW-1:0] model_tri(int idx, int cosv, int zb, int zc);
        int bx, by, cx, cy;
        logic last;
        bx   = (320 + floor_1024(-zb * cosv)) & 511;
        cx   = (320 + floor_1024(zc * cosv)) & 511;
        by   = (240 + zb) & 511;
        cy   = (240 + zc) & 511;
        last = (idx == NUM_TRI - 1);
        return {IW'(idx), last, 9'd320, 9'd120, 9'(bx), 9'(by), 9'(cx), 9'(cy)};
    endfunction

    // Scoreboard: every accepted triangle is popped against the model.
    always @(negedge clk_pix) begin
        logic [TW-1:0] act, expv;
        if (resetn && tb1.tri_valid && tb1.tri_ready) begin
            act = {tb1.tri_idx, tb1.tri_last, tb1.ax, tb1.ay, tb1.bx, tb1.by, tb1.cx, tb1.cy};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tri_sb_unexpected got=%h want=none", act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    bad++;
                    $display("FAIL tri_sb got=%h want=%h", act, expv);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic push_batch();
        for (int i = 0; i < NUM_TRI; i++)
            exp_q.push_back(model_tri(i, int'(cos_val), int'(zb_tab[i]), int'(zc_tab[i])));
    endtask

    task automatic pulse_fs();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk_pix);
            n++;
        end
        ok = !busy;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        @(negedge clk_pix);
        while (!tb1.tri_valid && n < 50) begin
            @(negedge clk_pix);
            n++;
        end
        ok = tb1.tri_valid;
    endtask

    task automatic test_basic();
        int cyc;
        bit ok;
        logic [1:0] exp_vb [0:2];
        exp_vb[0] = 2'b01; exp_vb[1] = 2'b11; exp_vb[2] = 2'b00;
        cos_val = 12'sd1024;
        zb_tab[0] = 7'd64; zc_tab[0] = 7'd32;
        zb_tab[1] = 7'd10; zc_tab[1] = 7'd20;
        ready = 1'b1;
        push_batch();
        pulse_fs();
        cyc = 0;
        @(negedge clk_pix);
        while (!tb1.tri_valid && cyc < 20) begin
            @(negedge clk_pix);
            cyc++;
        end
        total++;
        if (cyc !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", cyc); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_pix);
            total++;
            if ({tb1.tri_valid, busy} !== exp_vb[k]) begin
                bad++;
                $display("FAIL basic_valid_busy_seq%0d got=%b want=%b", k, {tb1.tri_valid, busy}, exp_vb[k]);
            end
        end
        wait_idle(ok);
        exp_angle = (exp_angle + 1) % 360;
        total++;
        if (rom_addr !== 9'(exp_angle)) begin bad++; $display("FAIL basic_angle got=%0d want=%0d", rom_addr, exp_angle); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL basic_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_neg_cos();
        bit ok;
        cos_val = -12'sd512;
        for (int i = 0; i < NUM_TRI; i++) begin zb_tab[i] = 7'd64; zc_tab[i] = 7'd64; end
        push_batch();
        pulse_fs();
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL negcos_timeout got=busy want=idle"); end
        exp_angle = (exp_angle + 1) % 360;
        total++;
        if (rom_addr !== 9'(exp_angle)) begin bad++; $display("FAIL negcos_angle got=%0d want=%0d", rom_addr, exp_angle); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [TW-1:0] act;
        cos_val = 12'($urandom_range(2048, 0)) - 12'sd1024;
        for (int i = 0; i < NUM_TRI; i++) begin
            zb_tab[i] = 7'($urandom_range(127, 0));
            zc_tab[i] = 7'($urandom_range(127, 0));
        end
        ready = 1'b0;
        push_batch();
        pulse_fs();
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_valid_timeout got=0 want=1"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_pix);
            act = {tb1.tri_idx, tb1.tri_last, tb1.ax, tb1.ay, tb1.bx, tb1.by, tb1.cx, tb1.cy};
            total++;
            if (exp_q.size() == 0 || !tb1.tri_valid || act !== exp_q[0]) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%h want=1/%h", k, tb1.tri_valid, act,
                         (exp_q.size() != 0) ? exp_q[0] : '0);
            end
        end
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        @(negedge clk_pix);
        total++;
        if ({tb1.tri_valid, tb1.tri_idx} !== 2'b01) begin
            bad++; $display("FAIL bp_gap got=%b want=01", {tb1.tri_valid, tb1.tri_idx});
        end
        @(negedge clk_pix);
        total++;
        if ({tb1.tri_valid, tb1.tri_idx} !== 2'b11) begin
            bad++; $display("FAIL bp_next got=%b want=11", {tb1.tri_valid, tb1.tri_idx});
        end
        ready = 1'b1;
        wait_idle(ok);
        exp_angle = (exp_angle + 1) % 360;
        total++;
        if (rom_addr !== 9'(exp_angle)) begin bad++; $display("FAIL bp_angle got=%0d want=%0d", rom_addr, exp_angle); end
    endtask

    task automatic test_drop();
        bit ok;
        int n;
        ready = 1'b0;
        push_batch();
        pulse_fs();
        wait_valid(ok);
        for (int k = 0; k < 3; k++) pulse_fs();
        @(negedge clk_pix);
        total++;
        if ({busy, fsm_state, tb1.tri_valid} !== 4'b1111 || rom_addr !== 9'(exp_angle)) begin
            bad++;
            $display("FAIL drop_stalled got=%b/%0d want=1111/%0d", {busy, fsm_state, tb1.tri_valid}, rom_addr, exp_angle);
        end
`ifdef VERT_SCHED_STATS_EN
        total++;
        if ({overrun, drop_cnt} !== {1'b1, 8'd3}) begin
            bad++; $display("FAIL drop_stats3 got=%b/%0d want=1/3", overrun, drop_cnt);
        end
`endif
        ready = 1'b1;
        n = 0;
        @(negedge clk_pix);
        while (!(tb1.tri_valid && tb1.tri_last) && n < 20) begin
            @(negedge clk_pix);
            n++;
        end
        frame_start = 1'b1;
        @(posedge clk_pix);
        #1;
        frame_start = 1'b0;
        exp_angle = (exp_angle + 1) % 360;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_pix);
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL drop_collision%0d got=%b want=0", k, busy); end
        end
        total++;
        if (rom_addr !== 9'(exp_angle)) begin bad++; $display("FAIL drop_angle got=%0d want=%0d", rom_addr, exp_angle); end
`ifdef VERT_SCHED_STATS_EN
        total++;
        if ({overrun, drop_cnt} !== {1'b1, 8'd4}) begin
            bad++; $display("FAIL drop_stats4 got=%b/%0d want=1/4", overrun, drop_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        bit ok;
        ready = 1'b0;
        push_batch();
        pulse_fs();
        wait_valid(ok);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        exp_angle = 0;
        #1;
        total++;
        if ({tb1.tri_valid, busy, fsm_state} !== 4'b0000) begin
            bad++; $display("FAIL reset_async got=%b want=0000", {tb1.tri_valid, busy, fsm_state});
        end
        tick();
        tick();
        resetn = 1'b1;
        @(negedge clk_pix);
        total++;
        if ({tb1.tri_valid, tb1.tri_last, tb1.tri_idx, busy, fsm_state} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000", {tb1.tri_valid, tb1.tri_last, tb1.tri_idx, busy, fsm_state});
        end
        total++;
        if (rom_addr !== 9'd0) begin bad++; $display("FAIL reset_angle got=%0d want=0", rom_addr); end
        total++;
        if ({tb1.ax, tb1.ay, tb1.bx, tb1.by, tb1.cx, tb1.cy} !== 54'd0) begin
            bad++; $display("FAIL reset_vertices got=%h want=0", {tb1.ax, tb1.ay, tb1.bx, tb1.by, tb1.cx, tb1.cy});
        end
`ifdef VERT_SCHED_STATS_EN
        total++;
        if ({overrun, drop_cnt} !== 9'd0) begin bad++; $display("FAIL reset_stats got=%b/%0d want=0/0", overrun, drop_cnt); end
`endif
    endtask

    task automatic test_angle_wrap();
        bit ok;
        ready = 1'b1;
        for (int b = 0; b < 360; b++) begin
            cos_val = 12'($urandom_range(2048, 0)) - 12'sd1024;
            for (int i = 0; i < NUM_TRI; i++) begin
                zb_tab[i] = 7'($urandom_range(127, 0));
                zc_tab[i] = 7'($urandom_range(127, 0));
            end
            push_batch();
            pulse_fs();
            wait_idle(ok);
            exp_angle = (exp_angle + 1) % 360;
            if (!ok) begin
                total++; bad++;
                $display("FAIL wrap_timeout got=busy want=idle batch=%0d", b);
                break;
            end
            if (b == 358 || b == 359) begin
                total++;
                if (rom_addr !== 9'(exp_angle)) begin
                    bad++; $display("FAIL wrap_angle%0d got=%0d want=%0d", b, rom_addr, exp_angle);
                end
            end
        end
    endtask

    task automatic test_angle_step();
        int exp2 = 0;
        int n;
        for (int k = 0; k < 4; k++) begin
            tick();
            frame_start2 = 1'b1;
            tick();
            frame_start2 = 1'b0;
            n = 0;
            while (busy2 && n < 50) begin
                @(negedge clk_pix);
                n++;
            end
            exp2 = (exp2 + 359) % 360;
            total++;
            if (busy2 !== 1'b0 || rom_addr2 !== 9'(exp2)) begin
                bad++; $display("FAIL step_angle%0d got=%0d busy=%b want=%0d", k, rom_addr2, busy2, exp2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_TRI; i++) begin zb_tab[i] = '0; zc_tab[i] = '0; end
        repeat (3) @(posedge clk_pix);
        #1;
        resetn = 1'b1;
        test_basic();
        test_neg_cos();
        test_backpressure();
        test_drop();
        test_reset();
        test_angle_wrap();
        test_angle_step();
        repeat (2) @(negedge clk_pix);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL final_sb_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vert_sched.md
Name: vert_sched

Overview:
Frame-synchronous scheduler for the vertex datapath. On each frame_start it fetches cos(angle) from the shared trig ROM (fixed read latency). It then computes NUM_TRI triangles in turn from a per-triangle depth table and hands each triangle to the rasterizer over a valid/ready handshake. Angle is advanced once per completed batch, so rotation is tied to frames instead of a free-running divider.

Parameters:
NUM_TRI, 4, triangles per batch (1..16); tri_idx width = max(1, clog2(NUM_TRI))
ROM_LAT, 2, trig ROM read latency in cycles (1..4)
ANGLE_STEP, 1, degrees added to angle per completed batch (1..359)

Ports:
clk_pix  in  1  pixel clock
resetn  in  1  reset, asynchronous, active-low
frame_start  in  1  one-cycle pulse at start of vblank
rom_addr  out  9  trig ROM address (= angle register, 0..359)
rom_data  in  12  signed Q1.10 cos, valid ROM_LAT cycles after rom_addr; range [-1024,1024]
tri_idx  out  IW  depth-table index of triangle being computed
z_b  in  7  depth of vertex B for tri_idx (combinational table)
z_c  in  7  depth of vertex C for tri_idx
tri_valid  out  1  triangle outputs valid
tri_ready  in  1  rasterizer accepts triangle
tri_last  out  1  high with tri_valid on the final triangle of batch
ax, ay, bx, by, cx, cy  out  9 each  vertex screen coordinates
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, angle=0, tri_idx=0, cos_r=0, wait counter=0, all vertex outputs=0, tri_valid=0, tri_last=0, busy=0.
- States: IDLE, FETCH, CALC, PRESENT.
- IDLE: frame_start=1 -> FETCH, wait counter=0, tri_idx=0.
- FETCH: rom_addr held at angle; counts ROM_LAT cycles. On the edge where counter==ROM_LAT-1: cos_r<=rom_data, go to CALC.
- CALC (1 cycle): register the vertex outputs from cos_r, z_b, z_c, then go to PRESENT:
  - ax=320, ay=120.
  - bx = 320 + P[18:10], where P = signed19({0,z_b} * -cos_r); by = 240 + z_b.
  - cx = 320 + Q[18:10], where Q = signed19({0,z_c} * cos_r); cy = 240 + z_c.
  - Additions are modulo 2^9; the arithmetic shift truncates toward -inf.
  - tri_last = (tri_idx == NUM_TRI-1).
- PRESENT: tri_valid=1. Outputs, tri_idx and tri_last stay stable until tri_ready=1 is sampled.
  - On handshake, not last: tri_idx++, go to CALC; tri_valid=0 for exactly one cycle.
  - On handshake, last: tri_valid=0, tri_idx=0, go to IDLE.
  - Angle update on the last handshake: angle = angle+ANGLE_STEP, minus 360 if the sum is >=360 (e.g. 359+1 -> 0, 358+5 -> 3).
- Latency: frame_start sampled at edge E0 -> tri_valid high after edge E0+ROM_LAT+1 (ROM_LAT FETCH cycles plus 1 CALC cycle). With tri_ready held high, a batch takes ROM_LAT + 2*NUM_TRI cycles.
- frame_start while busy=1 is dropped: no restart, angle unchanged. A frame_start in the same cycle as the last handshake is also dropped; IDLE is entered first.
- Vertex output registers keep their last values in IDLE.

Optional Feature:
Macro VERT_SCHED_STATS_EN.
- Defined: adds output overrun (1 bit, sticky; set by any dropped frame_start; cleared only by reset) and output drop_cnt (8 bits; increments per dropped frame_start and saturates at 255). Both reset to 0.
- Undefined: neither port exists and dropped frames are silent; all other behaviour is identical.

Test Plan:
- Reset: hold resetn=0 mid-PRESENT, then release -> tri_valid=0, busy=0, rom_addr=0, all vertex outputs 0, state IDLE.
- Basic batch (NUM_TRI=2, ROM_LAT=2): rom_data=1024; (z_b,z_c)=(64,32) then (10,20); tri_ready=1; pulse frame_start.
  - tri_valid rises 3 edges after the pulse.
  - Triangle 0: (320,120,256,304,352,272).
  - Triangle 1: bx=310, cx=340, tri_last=1.
  - rom_addr then reads 1.
- Negative cos: rom_data=-512, z_b=64, z_c=64 -> bx=352, by=304, cx=288, cy=304.
- Backpressure: tri_ready=0 for 10 cycles -> outputs and tri_idx stable, tri_valid held at 1; tri_ready=1 -> advances after exactly one handshake.
- Angle wrap: run 360 batches with ANGLE_STEP=1 -> rom_addr goes 359 -> 0. With ANGLE_STEP=5, starting from angle 358 -> 3.
- Overrun (VERT_SCHED_STATS_EN): pulse frame_start 3 times during a stalled batch -> overrun=1, drop_cnt=3, angle advances only once when the batch completes.
